// File: rtl/ball_frame_sampler_if.sv
// Bus between the ball frame sampler and its surroundings: VGA timing and
// processor position in, committed position and render flag out.
interface ball_frame_sampler_if;
    logic        screen_end;
    logic [31:0] ball_x;
    logic [31:0] ball_y;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [9:0]  disp_x;
    logic [8:0]  disp_y;
    logic        ball_on;
    logic        frame_valid;
    logic        oob;
    logic        overrun;
    logic [15:0] frame_count;

    modport master (
        output screen_end, ball_x, ball_y, pix_x, pix_y,
        input  disp_x, disp_y, ball_on, frame_valid,
        input  oob, overrun, frame_count
    );

    modport slave (
        input  screen_end, ball_x, ball_y, pix_x, pix_y,
        output disp_x, disp_y, ball_on, frame_valid,
        output oob, overrun, frame_count
    );
endinterface

// File: rtl/ball_frame_sampler.sv
// Samples the ball position once per frame, clamps it and drives ball_on.
// Define BALL_TRAIL_EN to also draw the previous position as a trail box.
module ball_frame_sampler #(
    parameter int XLIM      = 640,
    parameter int YLIM      = 480,
    parameter int BALL_SIZE = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    ball_frame_sampler_if.slave  bus
);
    localparam int XMAX = XLIM - BALL_SIZE;
    localparam int YMAX = YLIM - BALL_SIZE;
    localparam logic [9:0] XMAX_V = 10'(XMAX);
    localparam logic [8:0] YMAX_V = 9'(YMAX);
    localparam logic [9:0] X_CTR  = 10'(XMAX / 2);
    localparam logic [8:0] Y_CTR  = 9'(YMAX / 2);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE,
        CAP1,
        CAP2,
        COMMIT,
        HOLD
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [RW-1:0] retry_q;
    logic [RW-1:0] retry_d;
    logic          capture;
    logic          commit;

    logic          se_q;
    logic          armed;
    logic          se_edge;

    logic [31:0]   a_x;
    logic [31:0]   a_y;
    logic          stable;

    logic [9:0]    clamp_x;
    logic [8:0]    clamp_y;
    logic          clip_x;
    logic          clip_y;

    logic [9:0]    disp_x;
    logic [8:0]    disp_y;
    logic          ball_on;
    logic          frame_valid;
    logic          oob;
    logic          overrun;
    logic [15:0]   frame_count;
    logic          hit;

    // armed blocks an edge from a level already high when reset releases
    assign se_edge = bus.screen_end & ~se_q & armed;
    assign stable  = (bus.ball_x == a_x) && (bus.ball_y == a_y);

    function automatic logic in_box(
        input logic [9:0] bx,
        input logic [8:0] by,
        input logic [9:0] px,
        input logic [8:0] py
    );
        logic [10:0] x0;
        logic [10:0] xp;
        logic [9:0]  y0;
        logic [9:0]  yp;
        x0 = {1'b0, bx};
        xp = {1'b0, px};
        y0 = {1'b0, by};
        yp = {1'b0, py};
        return (xp >= x0) && (xp < x0 + 11'(BALL_SIZE)) &&
               (yp >= y0) && (yp < y0 + 10'(BALL_SIZE));
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        capture = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (se_edge) state_d = CAP1;
            end
            CAP1: begin
                capture = 1'b1;
                state_d = CAP2;
            end
            CAP2: begin
                if (stable) begin
                    state_d = COMMIT;
                end else if (retry_q < RETRY_MAX) begin
                    retry_d = retry_q + RW'(1);
                    state_d = CAP1;
                end else begin
                    state_d = HOLD;
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                retry_d = '0;
                state_d = IDLE;
            end
            HOLD: begin
                retry_d = '0;
                state_d = IDLE;
            end
            default: begin
                retry_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        clamp_x = a_x[9:0];
        clamp_y = a_y[8:0];
        clip_x  = 1'b0;
        clip_y  = 1'b0;
        if ($signed(a_x) < 0) begin
            clamp_x = '0;
            clip_x  = 1'b1;
        end else if ($signed(a_x) > XMAX) begin
            clamp_x = XMAX_V;
            clip_x  = 1'b1;
        end
        if ($signed(a_y) < 0) begin
            clamp_y = '0;
            clip_y  = 1'b1;
        end else if ($signed(a_y) > YMAX) begin
            clamp_y = YMAX_V;
            clip_y  = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            se_q  <= 1'b0;
            armed <= 1'b0;
            a_x   <= '0;
            a_y   <= '0;
        end else begin
            se_q  <= bus.screen_end;
            armed <= armed | ~bus.screen_end;
            if (capture) begin
                a_x <= bus.ball_x;
                a_y <= bus.ball_y;
            end
        end
    end

`ifdef BALL_TRAIL_EN
    logic [9:0] trail_x;
    logic [8:0] trail_y;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trail_x <= X_CTR;
            trail_y <= Y_CTR;
        end else if (commit) begin
            trail_x <= disp_x;
            trail_y <= disp_y;
        end
    end

    assign hit = in_box(disp_x, disp_y, bus.pix_x, bus.pix_y) |
                 in_box(trail_x, trail_y, bus.pix_x, bus.pix_y);
`else
    assign hit = in_box(disp_x, disp_y, bus.pix_x, bus.pix_y);
`endif

    // ball_on samples the display registers before a same-cycle commit lands
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            disp_x      <= X_CTR;
            disp_y      <= Y_CTR;
            ball_on     <= 1'b0;
            frame_valid <= 1'b0;
            oob         <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= '0;
        end else begin
            ball_on     <= hit;
            frame_valid <= commit;
            if (commit) begin
                disp_x      <= clamp_x;
                disp_y      <= clamp_y;
                oob         <= clip_x | clip_y;
                frame_count <= frame_count + 16'd1;
            end
            if (se_edge && (state_q != IDLE)) overrun <= 1'b1;
        end
    end

    assign bus.disp_x      = disp_x;
    assign bus.disp_y      = disp_y;
    assign bus.ball_on     = ball_on;
    assign bus.frame_valid = frame_valid;
    assign bus.oob         = oob;
    assign bus.overrun     = overrun;
    assign bus.frame_count = frame_count;

endmodule

// File: doc/ball_frame_sampler.md
BALL_FRAME_SAMPLER -- requirements
Module: ball_frame_sampler

Interface
REQ-001 The block SHALL have parameter XLIM, default 640, meaning screen width in pixels.
REQ-002 The block SHALL have parameter YLIM, default 480, meaning screen height in pixels.
REQ-003 The block SHALL have parameter BALL_SIZE, default 8, meaning ball square side in pixels.
REQ-004 The block SHALL have parameter MAX_RETRY, default 3, meaning unstable-sample retries before hold.
REQ-005 The block SHALL have port clock, input, 1, meaning the single clock; all logic rises on it.
REQ-006 The block SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-007 The block SHALL have port screen_end, input, 1, meaning a level from the VGA timing, high during vertical blank.
REQ-008 The block SHALL have port ball_x, input, 32, meaning the signed processor-written ball x.
REQ-009 The block SHALL have port ball_y, input, 32, meaning the signed processor-written ball y.
REQ-010 The block SHALL have port pix_x, input, 10, meaning the current scan column.
REQ-011 The block SHALL have port pix_y, input, 9, meaning the current scan row.
REQ-012 The block SHALL have port disp_x, output, 10, meaning the committed, clamped ball x.
REQ-013 The block SHALL have port disp_y, output, 9, meaning the committed, clamped ball y.
REQ-014 The block SHALL have port ball_on, output, 1, meaning the registered pixel-inside-ball flag.
REQ-015 The block SHALL have port frame_valid, output, 1, meaning a one-cycle pulse on each commit.
REQ-016 The block SHALL have port oob, output, 1, meaning the last committed sample needed clamping.
REQ-017 The block SHALL have port overrun, output, 1, meaning a sticky flag set when a screen_end edge is missed.
REQ-018 The block SHALL have port frame_count, output, 16, meaning a count of commits.

Function
REQ-019 screen_end rising edge SHALL be detected against a registered copy; edge seen in cycle N moves the FSM IDLE->CAP1 at edge N+1.
- FSM states: IDLE, CAP1, CAP2, COMMIT, HOLD.
REQ-020 In CAP1 the block SHALL register ball_x/ball_y as sample A, then go to CAP2.
REQ-021 In CAP2 the block SHALL compare current ball_x/ball_y with A.
- Equal: go to COMMIT.
- Unequal with retry count < MAX_RETRY: increment retry and return to CAP1.
- Otherwise: go to HOLD.
REQ-022 COMMIT SHALL clamp and load the display registers, pulse frame_valid for exactly one cycle, increment frame_count (wrapping 0xFFFF->0x0000), clear retry, and return to IDLE.
- Clamping: x<0 -> 0; x>XLIM-BALL_SIZE -> XLIM-BALL_SIZE; y likewise with YLIM.
- oob SHALL be 1 if either axis clamped, else 0.
REQ-023 HOLD SHALL keep the previous display values, leave frame_count and oob unchanged, assert no frame_valid, clear retry, and return to IDLE after one cycle.
REQ-024 A screen_end rising edge detected while the state is not IDLE SHALL be ignored and SHALL set overrun.
- overrun clears only on reset.
REQ-025 ball_on SHALL be registered and valid one cycle after pix_x/pix_y.
- It SHALL be 1 when disp_x<=pix_x<disp_x+BALL_SIZE and disp_y<=pix_y<disp_y+BALL_SIZE, with comparisons done in 11/10-bit widths so no wrap occurs.
REQ-026 A commit and a pixel lookup in the same cycle SHALL use pre-commit display values for that cycle's ball_on.

Reset
REQ-027 Asserting reset (low) at any time, including mid-capture, SHALL asynchronously force the following:
- state=IDLE
- disp_x=(XLIM-BALL_SIZE)/2 and disp_y=(YLIM-BALL_SIZE)/2
- ball_on=0, frame_valid=0, oob=0, overrun=0, frame_count=0
- retry=0, and the edge register cleared
REQ-028 After deassertion, screen_end already high SHALL NOT produce an edge until it goes low then high.

Configuration
REQ-029 With macro BALL_TRAIL_EN defined, each COMMIT SHALL copy the old disp_x/disp_y into trail registers, and ball_on SHALL also assert inside the trail box.
- Trail registers SHALL be reset to the same centre value as disp_x/disp_y.
REQ-030 Without BALL_TRAIL_EN, no trail registers SHALL exist and ball_on SHALL reflect the current box only.

Verification
REQ-031 Steady input: ball_x=100, ball_y=50, one screen_end pulse -> frame_valid pulses 4 cycles after the edge cycle, disp=(100,50), oob=0, frame_count=1.
REQ-032 Clamp: ball_x=-5, ball_y=1000 -> disp=(0,472), oob=1.
REQ-033 Unstable: ball_x changes every cycle through 4 compares -> HOLD, no frame_valid, disp unchanged, frame_count unchanged.
REQ-034 Overrun: a second screen_end edge during CAP2 -> it is ignored, overrun=1, and the single commit completes.
REQ-035 Render: disp=(100,50); pix=(107,57) -> ball_on=1 next cycle; pix=(108,57) -> ball_on=0.
- With BALL_TRAIL_EN: move to (200,50); pix=(100,50) -> ball_on=1.
REQ-036 Reset during CAP2 -> outputs at reset values, state IDLE, no frame_valid after release.
